// File: rtl/io_read_port_buffer.sv
// Per-port receive buffer between an external producer and the datapath
// read mux. Words arrive over valid/ready, sit in a small circular FIFO,
// and are popped into a registered read_data when predication issues a
// gated io_rden. The status flags are decoded only from the registered
// count, so predication never sees a combinational path from its own
// read enable or from the producer.
module io_read_port_buffer #(
   parameter int WORD_WIDTH  = 36,
   parameter int DEPTH       = 4,
   parameter int DEPTH_WIDTH = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [WORD_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   io_rden,
   output logic                   read_EF,
   output logic [WORD_WIDTH-1:0]  read_data,
   output logic [DEPTH_WIDTH:0]   occupancy,
   output logic                   underflow
);

   // Count value meaning "every slot holds a word".
   localparam logic [DEPTH_WIDTH:0] FullCount = (DEPTH_WIDTH + 1)'(DEPTH);

   logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
   logic [DEPTH_WIDTH-1:0] wptr_q, wptr_d;
   logic [DEPTH_WIDTH-1:0] rptr_q, rptr_d;
   logic [DEPTH_WIDTH:0]   count_q, count_d;
   logic [WORD_WIDTH-1:0]  read_data_q, read_data_d;
   logic                   underflow_q, underflow_d;
   logic                   push;
   logic                   pop;

   // The count carries one extra bit so a full buffer and an empty one
   // never alias, which keeps both flags single compares.
   assign in_ready  = (count_q != FullCount);
   assign read_EF   = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = io_rden & read_EF;
   assign read_data = read_data_q;
   assign occupancy = count_q;
   assign underflow = underflow_q;

   // Next-state for pointers, count, output word and the sticky error.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      read_data_d = read_data_q;
      underflow_d = underflow_q;

      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end

      if (pop) begin
         rptr_d      = rptr_q + 1'b1;
         read_data_d = mem_q[rptr_q];
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (io_rden && !read_EF) begin
         underflow_d = 1'b1;
      end
   end

   // Control state; everything a consumer can observe clears on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         read_data_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         read_data_q <= read_data_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; stale contents are unreachable after reset because
   // the pointers and count are cleared, so it carries no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_io_read_port_buffer.sv
// Self-checking bench for io_read_port_buffer. A queue-based reference
// model tracks the buffered words, the last popped word and the sticky
// underflow flag; directed scenarios and a randomized run compare the
// DUT outputs against it.
module tb_io_read_port_buffer;

   localparam int WORD_WIDTH  = 36;
   localparam int DEPTH       = 4;
   localparam int DEPTH_WIDTH = 2;

   logic                   clock;
   logic                   reset_n;
   logic [WORD_WIDTH-1:0]  in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic                   io_rden;
   logic                   read_EF;
   logic [WORD_WIDTH-1:0]  read_data;
   logic [DEPTH_WIDTH:0]   occupancy;
   logic                   underflow;

   int vectors;
   int miscompares;

   logic [WORD_WIDTH-1:0] mq[$];
   logic [WORD_WIDTH-1:0] mRead;
   logic                  mUnder;

   io_read_port_buffer #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH),
      .DEPTH_WIDTH(DEPTH_WIDTH)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .io_rden  (io_rden),
      .read_EF  (read_EF),
      .read_data(read_data),
      .occupancy(occupancy),
      .underflow(underflow)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Synchronous-looking reset pulse spanning one rising edge; the model empties.
   task automatic doReset();
      in_valid = 1'b0;
      in_data  = '0;
      io_rden  = 1'b0;
      reset_n  = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      mq.delete();
      mRead  = '0;
      mUnder = 1'b0;
   endtask

   // Drives one cycle of inputs and advances the reference model by the
   // FIFO rules: accept when not full, deliver when not empty.
   task automatic tick(input logic v, input logic [WORD_WIDTH-1:0] d, input logic r);
      bit mPush;
      bit mPop;
      in_valid = v;
      in_data  = d;
      io_rden  = r;
      mPush = v && (mq.size() < DEPTH);
      mPop  = r && (mq.size() != 0);
      if (r && mq.size() == 0) mUnder = 1'b1;
      @(posedge clock);
      #1;
      if (mPop)  mRead = mq.pop_front();
      if (mPush) mq.push_back(d);
   endtask

   task automatic test_reset();
      doReset();
      vectors += 5;
      if (read_EF !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_EF: got %b expected 0", read_EF); end
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
      if (occupancy !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
      if (read_data !== 36'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", read_data); end
      if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
   endtask

   task automatic test_first_push();
      doReset();
      in_valid = 1'b1;
      in_data  = 36'h000000001;
      #1;
      vectors++;
      if (read_EF !== 1'b0) begin miscompares++; $display("[TB] FAIL first_push_EF_same_cycle: got %b expected 0", read_EF); end
      tick(1'b1, 36'h000000001, 1'b0);
      in_valid = 1'b0;
      vectors += 3;
      if (read_EF !== 1'b1) begin miscompares++; $display("[TB] FAIL first_push_EF_next: got %b expected 1", read_EF); end
      if (occupancy !== 3'd1) begin miscompares++; $display("[TB] FAIL first_push_occ: got %0d expected 1", occupancy); end
      if (read_data !== 36'h0) begin miscompares++; $display("[TB] FAIL first_push_data: got %h expected 0", read_data); end
   endtask

   task automatic test_fill_full();
      logic [WORD_WIDTH-1:0] expd [4];
      expd = '{36'hB, 36'hC, 36'hD, 36'hE};
      doReset();
      tick(1'b1, 36'hA, 1'b0);
      tick(1'b1, 36'hB, 1'b0);
      tick(1'b1, 36'hC, 1'b0);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready_3: got %b expected 1", in_ready); end
      tick(1'b1, 36'hD, 1'b0);
      vectors += 2;
      if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_ready_full: got %b expected 0", in_ready); end
      if (occupancy !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_occ_full: got %0d expected 4", occupancy); end
      tick(1'b1, 36'hE, 1'b1);
      vectors += 3;
      if (read_data !== 36'hA) begin miscompares++; $display("[TB] FAIL full_pop_data: got %h expected a", read_data); end
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop_ready: got %b expected 1", in_ready); end
      if (occupancy !== 3'd3) begin miscompares++; $display("[TB] FAIL full_pop_occ: got %0d expected 3", occupancy); end
      tick(1'b1, 36'hE, 1'b0);
      vectors += 2;
      if (occupancy !== 3'd4) begin miscompares++; $display("[TB] FAIL pending_accept_occ: got %0d expected 4", occupancy); end
      if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL pending_accept_ready: got %b expected 0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, '0, 1'b1);
         vectors++;
         if (read_data !== expd[i]) begin
            miscompares++;
            $display("[TB] FAIL drain_order[%0d]: got %h expected %h", i, read_data, expd[i]);
         end
      end
      io_rden = 1'b0;
   endtask

   task automatic test_back_to_back();
      doReset();
      tick(1'b1, 36'd1, 1'b0);
      for (int i = 2; i <= 10; i++) begin
         tick(1'b1, 36'(i), 1'b1);
         vectors += 2;
         if (read_data !== 36'(i - 1)) begin
            miscompares++;
            $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i - 1, read_data, 36'(i - 1));
         end
         if (occupancy !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL stream_occ[%0d]: got %0d expected 1", i - 1, occupancy);
         end
      end
      tick(1'b0, '0, 1'b1);
      io_rden = 1'b0;
      vectors += 2;
      if (read_data !== 36'd10) begin miscompares++; $display("[TB] FAIL stream_last: got %h expected a", read_data); end
      if (read_EF !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_empty: got %b expected 0", read_EF); end
   endtask

   task automatic test_underflow();
      doReset();
      tick(1'b1, 36'h123, 1'b0);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      vectors += 3;
      if (read_data !== 36'h123) begin miscompares++; $display("[TB] FAIL underflow_data_hold: got %h expected 123", read_data); end
      if (occupancy !== 3'd0) begin miscompares++; $display("[TB] FAIL underflow_occ: got %0d expected 0", occupancy); end
      if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL underflow_set: got %b expected 1", underflow); end
      for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0);
      vectors++;
      if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL underflow_sticky: got %b expected 1", underflow); end
   endtask

   // Runs with underflow still set from the previous scenario so the
   // asynchronous clear of the sticky flag is visible.
   task automatic test_reset_mid();
      tick(1'b1, 36'h111, 1'b0);
      tick(1'b1, 36'h222, 1'b1);
      tick(1'b1, 36'h333, 1'b0);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      vectors += 4;
      if (read_EF !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_EF: got %b expected 0", read_EF); end
      if (occupancy !== 3'd0) begin miscompares++; $display("[TB] FAIL midreset_occ: got %0d expected 0", occupancy); end
      if (read_data !== 36'h0) begin miscompares++; $display("[TB] FAIL midreset_data: got %h expected 0", read_data); end
      if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_underflow: got %b expected 0", underflow); end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      mq.delete();
      mRead  = '0;
      mUnder = 1'b0;
      tick(1'b1, 36'h777, 1'b0);
      tick(1'b0, '0, 1'b1);
      io_rden = 1'b0;
      vectors++;
      if (read_data !== 36'h777) begin miscompares++; $display("[TB] FAIL midreset_fresh: got %h expected 777", read_data); end
   endtask

   task automatic test_push_pop_same();
      doReset();
      tick(1'b1, 36'h9, 1'b0);
      tick(1'b1, 36'h5, 1'b1);
      vectors += 3;
      if (read_data !== 36'h9) begin miscompares++; $display("[TB] FAIL pushpop_data: got %h expected 9", read_data); end
      if (occupancy !== 3'd1) begin miscompares++; $display("[TB] FAIL pushpop_occ: got %0d expected 1", occupancy); end
      if (read_EF !== 1'b1) begin miscompares++; $display("[TB] FAIL pushpop_EF: got %b expected 1", read_EF); end
      tick(1'b0, '0, 1'b1);
      io_rden = 1'b0;
      vectors++;
      if (read_data !== 36'h5) begin miscompares++; $display("[TB] FAIL pushpop_next: got %h expected 5", read_data); end
   endtask

   // Random traffic; the producer holds a pending word until accepted.
   task automatic test_random();
      logic                  pv;
      logic [WORD_WIDTH-1:0] pd;
      logic                  r;
      bit                    accepted;
      doReset();
      pv = 1'b0;
      pd = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 99) < 60);
            pd = {4'($urandom_range(0, 15)), 32'($urandom)};
         end
         r = ($urandom_range(0, 99) < 45);
         accepted = pv && (mq.size() < DEPTH);
         tick(pv, pd, r);
         if (accepted) pv = 1'b0;
         vectors += 5;
         if (read_data !== mRead) begin miscompares++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, read_data, mRead); end
         if (occupancy !== 3'(mq.size())) begin miscompares++; $display("[TB] FAIL rand_occ[%0d]: got %0d expected %0d", n, occupancy, mq.size()); end
         if (read_EF !== (mq.size() != 0)) begin miscompares++; $display("[TB] FAIL rand_EF[%0d]: got %b expected %b", n, read_EF, mq.size() != 0); end
         if (in_ready !== (mq.size() < DEPTH)) begin miscompares++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, mq.size() < DEPTH); end
         if (underflow !== mUnder) begin miscompares++; $display("[TB] FAIL rand_underflow[%0d]: got %b expected %b", n, underflow, mUnder); end
      end
      in_valid = 1'b0;
      io_rden  = 1'b0;
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      io_rden     = 1'b0;
      mRead       = '0;
      mUnder      = 1'b0;
      test_reset();
      test_first_push();
      test_fill_full();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      test_push_pop_same();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
